// File: rtl/instr_pkg.sv
// Shared types, constants and helpers for the instruction aligner.
// RVC_EN is the only configuration macro and is consumed by instr_aligner.
package instr_pkg;

    typedef logic [15:0] halfword_t;

    localparam int unsigned BUF_DEPTH        = 4;
    localparam int unsigned CNT_W            = 3;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_compressed(input halfword_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_hw_buf.sv
// Four-entry halfword FIFO, head at entry 0; pops shift the array down and
// pushes append behind whatever survives the pop in the same cycle.
module instr_hw_buf
    import instr_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push2_i,
    input  logic             push_hi_i,
    input  logic             pop1_i,
    input  logic             pop2_i,
    input  logic [31:0]      data_i,
    output logic [CNT_W-1:0] count_o,
    output halfword_t        head_o,
    output halfword_t        next_o
);

    halfword_t [BUF_DEPTH-1:0] hw_q, hw_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          pop_n;
    logic [CNT_W-1:0]          rem;
    logic [1:0]                wr_idx;

    always_comb begin
        hw_d   = hw_q;
        cnt_d  = cnt_q;
        pop_n  = pop2_i ? CNT_W'(2) : (pop1_i ? CNT_W'(1) : CNT_W'(0));
        rem    = cnt_q - pop_n;
        wr_idx = rem[1:0];
        if (clear_i) begin
            hw_d  = '0;
            cnt_d = '0;
        end else begin
            case (pop_n)
                CNT_W'(1): hw_d = {16'h0000, hw_q[3:1]};
                CNT_W'(2): hw_d = {32'h0000_0000, hw_q[3:2]};
                default:   hw_d = hw_q;
            endcase
            // The aligner only pushes when count <= 2, so wr_idx + 1 never wraps.
            if (push2_i) begin
                hw_d[wr_idx]        = data_i[15:0];
                hw_d[wr_idx + 2'd1] = data_i[31:16];
                cnt_d               = rem + CNT_W'(2);
            end else if (push_hi_i) begin
                hw_d[wr_idx] = data_i[31:16];
                cnt_d        = rem + CNT_W'(1);
            end else begin
                cnt_d = rem;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hw_q  <= '0;
            cnt_q <= '0;
        end else begin
            hw_q  <= hw_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = hw_q[0];
    assign next_o  = hw_q[1];

endmodule

// File: rtl/instr_aligner.sv
// Realigns a stream of 32-bit fetch words into whole instructions with their PCs.
// Define RVC_EN to handle 16-bit compressed instructions; otherwise all are 32-bit.
module instr_aligner
    import instr_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_compressed,
    output logic [31:0] out_pc
);

    logic [CNT_W-1:0] count;
    halfword_t        head;
    halfword_t        next;
    logic [31:0]      pc_q, pc_d;
    logic             drop_lo_q, drop_lo_d;
    logic             accept;
    logic             consume;
    logic             head_comp;

    // Registered-only ready: no combinational path from out_ready.
    assign fetch_ready = (count <= CNT_W'(2));
    assign accept      = fetch_valid && fetch_ready && !flush;

`ifdef RVC_EN
    assign head_comp = (count != '0) && is_compressed(head);
    assign out_valid = !flush && ((count >= CNT_W'(2)) || ((count == CNT_W'(1)) && head_comp));
`else
    assign head_comp = 1'b0;
    assign out_valid = !flush && (count >= CNT_W'(2));
`endif

    assign consume        = out_valid && out_ready;
    assign out_compressed = head_comp;
    assign out_instr      = head_comp ? {16'h0000, head} : {next, head};
    assign out_pc         = pc_q;

    instr_hw_buf u_hw_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (flush),
        .push2_i   (accept && !drop_lo_q),
        .push_hi_i (accept && drop_lo_q),
        .pop1_i    (consume && head_comp),
        .pop2_i    (consume && !head_comp),
        .data_i    (fetch_data),
        .count_o   (count),
        .head_o    (head),
        .next_o    (next)
    );

    always_comb begin
        pc_d      = pc_q;
        drop_lo_d = drop_lo_q;
        if (flush) begin
            pc_d = flush_pc;
`ifdef RVC_EN
            drop_lo_d = flush_pc[1];
`else
            drop_lo_d = 1'b0;
`endif
        end else begin
            if (consume) begin
                pc_d = pc_q + (head_comp ? 32'd2 : 32'd4);
            end
            if (accept) begin
                drop_lo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            drop_lo_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            drop_lo_q <= drop_lo_d;
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Directed bench for instr_aligner; expectations follow RVC_EN when it is defined.
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_data = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_compressed;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    instr_aligner dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_data     (fetch_data),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_compressed (out_compressed),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] instr,
                              input logic [31:0] pc, input logic comp);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check_eq({tag, ".instr"}, out_instr, instr);
            check_eq({tag, ".pc"}, out_pc, pc);
            check_eq({tag, ".comp"}, 32'(out_compressed), 32'(comp));
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".ready"}, 32'(fetch_ready), 32'd1);
        check_eq({tag, ".instr"}, out_instr, 32'd0);
        check_eq({tag, ".comp"}, 32'(out_compressed), 32'd0);
        check_eq({tag, ".pc"}, out_pc, 32'd0);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        tick();
        flush = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        fetch_valid = 1'b1;
        fetch_data  = w;
        tick();
        fetch_valid = 1'b0;
    endtask

    logic [31:0] got_i [3];
    logic [31:0] got_p [3];
    logic [31:0] exp_i [3];
    logic [31:0] exp_p [3];
    int          n_got;
    logic        hs_out;
    logic        hs_in;

    initial begin
        #12;
        check_idle("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Two aligned 32-bit instructions
        out_ready = 1'b0;
        fetch_valid = 1'b1;
        fetch_data  = 32'h00A0_0093;
        tick();
        fetch_data  = 32'h00B0_0113;
        tick();
        fetch_valid = 1'b0;
        check_eq("full.fetch_ready", 32'(fetch_ready), 32'd0);
        expect_out("w32a", 1'b1, 32'h00A0_0093, 32'h0, 1'b0);
        out_ready = 1'b1;
        tick();
        expect_out("w32b", 1'b1, 32'h00B0_0113, 32'h4, 1'b0);
        tick();
        expect_out("w32_empty", 1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("w32_empty.pc", out_pc, 32'h8);

        // Word holding two compressed halfwords
        do_flush(32'h0);
        out_ready = 1'b0;
        push_word(32'h0505_4501);
`ifdef RVC_EN
        expect_out("cc_a", 1'b1, 32'h0000_4501, 32'h0, 1'b1);
        out_ready = 1'b1;
        tick();
        expect_out("cc_b", 1'b1, 32'h0000_0505, 32'h2, 1'b1);
        tick();
`else
        expect_out("cc_a", 1'b1, 32'h0505_4501, 32'h0, 1'b0);
        out_ready = 1'b1;
        tick();
`endif
        expect_out("cc_empty", 1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("cc_empty.pc", out_pc, 32'h4);

        // 32-bit instruction straddling two fetch words
        do_flush(32'h0);
        out_ready = 1'b1;
        push_word(32'h0093_4501);
`ifdef RVC_EN
        expect_out("mis_c", 1'b1, 32'h0000_4501, 32'h0, 1'b1);
        tick();
        expect_out("mis_wait1", 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        expect_out("mis_wait2", 1'b0, 32'h0, 32'h0, 1'b0);
        push_word(32'h1111_00A0);
        expect_out("mis_w", 1'b1, 32'h00A0_0093, 32'h2, 1'b0);
        tick();
        expect_out("mis_tail", 1'b1, 32'h0000_1111, 32'h6, 1'b1);
        tick();
`else
        expect_out("mis_a", 1'b1, 32'h0093_4501, 32'h0, 1'b0);
        tick();
        expect_out("mis_wait1", 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        expect_out("mis_wait2", 1'b0, 32'h0, 32'h0, 1'b0);
        push_word(32'h1111_00A0);
        expect_out("mis_b", 1'b1, 32'h1111_00A0, 32'h4, 1'b0);
        tick();
`endif
        expect_out("mis_empty", 1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("mis_empty.pc", out_pc, 32'h8);

        // Flush to an odd-halfword PC
        do_flush(32'h0000_0102);
        expect_out("fl_idle", 1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("fl_idle.pc", out_pc, 32'h102);
        out_ready = 1'b0;
        push_word(32'h4505_4501);
`ifdef RVC_EN
        expect_out("fl_hi", 1'b1, 32'h0000_4505, 32'h102, 1'b1);
        out_ready = 1'b1;
        tick();
        check_eq("fl_done.pc", out_pc, 32'h104);
`else
        expect_out("fl_w", 1'b1, 32'h4505_4501, 32'h102, 1'b0);
        out_ready = 1'b1;
        tick();
        check_eq("fl_done.pc", out_pc, 32'h106);
`endif
        check_eq("fl_done.valid", 32'(out_valid), 32'd0);

        // Backpressure: hold out_ready low with a third word waiting
        do_flush(32'h0);
        out_ready = 1'b0;
        fetch_valid = 1'b1;
        fetch_data  = 32'h00A0_0093;
        tick();
        fetch_data  = 32'h00B0_0113;
        tick();
        fetch_data  = 32'h00C0_0193;
        for (int c = 0; c < 5; c++) begin
            check_eq("bp.fetch_ready", 32'(fetch_ready), 32'd0);
            expect_out("bp.hold", 1'b1, 32'h00A0_0093, 32'h0, 1'b0);
            tick();
        end
        exp_i = '{32'h00A0_0093, 32'h00B0_0113, 32'h00C0_0193};
        exp_p = '{32'h0, 32'h4, 32'h8};
        got_i = '{32'h0, 32'h0, 32'h0};
        got_p = '{32'h0, 32'h0, 32'h0};
        n_got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && n_got < 3; c++) begin
            hs_out = out_valid && out_ready;
            hs_in  = fetch_valid && fetch_ready;
            if (hs_out) begin
                got_i[n_got] = out_instr;
                got_p[n_got] = out_pc;
                n_got++;
            end
            tick();
            if (hs_in) fetch_valid = 1'b0;
        end
        check_eq("bp.count", 32'(n_got), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check_eq("bp.drain_instr", got_i[k], exp_i[k]);
            check_eq("bp.drain_pc", got_p[k], exp_p[k]);
        end
        check_eq("bp.fetch_valid_dropped", 32'(fetch_valid), 32'd0);

        // Flush and fetch handshake in the same cycle
        out_ready = 1'b0;
        push_word(32'h00A0_0093);
        expect_out("ff_pre", 1'b1, 32'h00A0_0093, 32'hC, 1'b0);
        flush       = 1'b1;
        flush_pc    = 32'h0000_0040;
        fetch_valid = 1'b1;
        fetch_data  = 32'h00B0_0113;
        #1;
        check_eq("ff_same.valid", 32'(out_valid), 32'd0);
        check_eq("ff_same.ready", 32'(fetch_ready), 32'd1);
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        check_eq("ff_next.valid", 32'(out_valid), 32'd0);
        check_eq("ff_next.ready", 32'(fetch_ready), 32'd1);
        check_eq("ff_next.pc", out_pc, 32'h40);
        push_word(32'h00C0_0193);
        expect_out("ff_after", 1'b1, 32'h00C0_0193, 32'h40, 1'b0);
        out_ready = 1'b1;
        tick();
        check_eq("ff_drain.valid", 32'(out_valid), 32'd0);

        // Asynchronous reset with data buffered
        out_ready = 1'b0;
        push_word(32'h00A0_0093);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_word(32'h00B0_0113);
        expect_out("post_async", 1'b1, 32'h00B0_0113, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_aligner.md
INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC of the first instruction after reset.
REQ-002 SHALL have port: clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: fetch_valid  input  1  fetch_data is valid.
REQ-005 SHALL have port: fetch_ready  output  1  aligner can take a word this cycle.
REQ-006 SHALL have port: fetch_data  input  32  word-aligned instruction-memory word, little-endian halfwords.
REQ-007 SHALL have port: flush  input  1  redirect request: discard all buffered state.
REQ-008 SHALL have port: flush_pc  input  32  new PC on flush, halfword aligned.
REQ-009 SHALL have port: out_valid  output  1  out_instr holds a complete instruction.
REQ-010 SHALL have port: out_ready  input  1  decompression stage accepts out_instr.
REQ-011 SHALL have port: out_instr  output  32  raw instruction; compressed form in [15:0] with [31:16]=0.
REQ-012 SHALL have port: out_compressed  output  1  out_instr is 16-bit (bits[1:0] != 2'b11).
REQ-013 SHALL have port: out_pc  output  32  address of out_instr.

Function
REQ-014 SHALL hold a halfword buffer of 4 entries, with occupancy count 0..4 as the state.
REQ-015 SHALL accept a word when fetch_valid && fetch_ready, appending its low then high halfword.
REQ-016 SHALL drive fetch_ready = (count <= 2), taken from registered state only, with no path from out_ready.
REQ-017 SHALL assert out_valid when count>=2, or when count==1 and the head halfword is compressed.
REQ-018 SHALL keep out_valid low when count==1 and the head is the first half of a 32-bit instruction; the instruction waits for its upper half.
REQ-019 SHALL consume 1 halfword for a compressed instruction and 2 halfwords otherwise on out_valid && out_ready.
REQ-020 SHALL make out_instr, out_compressed and out_pc combinational from registers; zero latency from buffer head to output.
REQ-021 SHALL allow accept and consume in the same cycle: next count = count - consumed + 2*accepted.
REQ-022 SHALL add out_pc by 2 or 4 on each consume, wrapping modulo 2^32.
REQ-023 SHALL, on flush, set count=0 and out_pc=flush_pc, and set drop_lo=flush_pc[1].
REQ-024 SHALL give flush priority over accept and consume in the same cycle: out_valid forced low and any word handshaked that cycle discarded.
REQ-025 SHALL, when drop_lo=1, append only the high halfword of the next accepted word and then clear drop_lo.
REQ-026 SHALL keep out_instr, out_compressed and out_pc stable while out_valid && !out_ready.

Reset
REQ-027 SHALL, on rst high asynchronously, set count=0, drop_lo=0, out_pc=RESET_PC, buffer contents=0.
REQ-028 SHALL, while reset is asserted and after release, drive out_valid=0, out_compressed=0, out_instr=0 and fetch_ready=1.
REQ-029 SHALL discard a partial instruction held when rst asserts mid-operation.

Configuration
REQ-030 SHALL, with RVC_EN defined, implement compressed-instruction handling as specified above.
REQ-031 SHALL, without RVC_EN, treat every instruction as 32-bit, tie out_compressed=0, ignore flush_pc[1] (drop_lo always 0) and step out_pc by 4.

Structure
REQ-032 SHALL put these items in shared package instr_pkg:
- halfword typedef
- count width constant
- is_compressed function (bits[1:0] != 2'b11)
- RESET_PC default
REQ-033 SHALL place the 4-entry halfword buffer in sub-module instr_hw_buf, with ports for push-2, pop-1/2, clear, push-high-only and count.

Verification
REQ-034 SHALL cover: reset, then words 32'h00A00093, 32'h00B00113 -> two 32-bit outputs, out_pc 0 then 4, out_compressed=0.
REQ-035 SHALL cover: word 32'h0505_4501 -> two compressed outputs, 16'h4501 at pc 0 and 16'h0505 at pc 2.
REQ-036 SHALL cover: misaligned 32-bit case, words 32'h0093_4501 then 32'h1111_00A0.
- Required: C 16'h4501 at pc 0, then 32'h00A00093 at pc 2, out_valid held low until the second word arrives.
REQ-037 SHALL cover: flush with flush_pc=32'h0000_0102, then word 32'h4505_4501 -> only 16'h4505 output, at pc 0x102.
REQ-038 SHALL cover: out_ready=0 for 5 cycles with count reaching 3 -> fetch_ready=0, outputs stable, no loss after release.
REQ-039 SHALL cover: flush and fetch handshake in the same cycle -> word discarded, out_valid=0 that cycle, count=0 next cycle.
